// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory bus arbiter.
// Holds the FSM and owner encodings plus the round-robin pick helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int WDOG_W      = 8;

  // When both sides ask, the side that was not served last wins.
  function automatic owner_e rr_pick(input logic f_req, input logic d_req,
                                     input owner_e last);
    if (f_req && d_req) return (last == DATA) ? FETCH : DATA;
    return f_req ? FETCH : DATA;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait counter for an outstanding memory access; flags the cycle in which
// the limit-th consecutive wait is being spent.
module mem_arb_wdog
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              expired_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == limit_i - WDOG_W'(1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// side and a data side, with one outstanding transaction and an ack timeout.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_e            dbg_state_o
);

  localparam logic [WDOG_W-1:0] TO_LIMIT = WDOG_W'(TIMEOUT);

  // Requesters present req with stable fields until their gnt; the gnt pulse
  // marks the request as consumed, and rvalid later closes it out.
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, last_q, last_d, winner;
  logic              first_q, first_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] resp_data;
  logic              wd_clear, wd_en, wd_expired;

  mem_arb_wdog u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .limit_i   (TO_LIMIT),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    first_d   = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    resp_data = '0;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    winner    = rr_pick(i_req, d_req, last_q);
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = winner;
          if (winner == FETCH) begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end else begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
          first_d  = 1'b1;
          wd_clear = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // An ack in the same cycle as expiry still completes cleanly.
        if (mem_ack || wd_expired) begin
          state_d   = RESP;
          err_d     = !mem_ack;
          resp_data = (mem_ack && !we_q) ? mem_rdata : '0;
          if (owner_q == FETCH) i_rdata_d = resp_data;
          else                  d_rdata_d = resp_data;
        end else begin
          wd_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= DATA;
      last_q    <= DATA;
      first_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      first_q   <= first_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req     = (state_q == BUSY);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_gnt       = mem_req && first_q && (owner_q == FETCH);
  assign d_gnt       = mem_req && first_q && (owner_q == DATA);
  assign i_rvalid    = (state_q == RESP) && (owner_q == FETCH);
  assign d_rvalid    = (state_q == RESP) && (owner_q == DATA);
  assign i_err       = i_rvalid && err_q;
  assign d_err       = d_rvalid && err_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int TO_MAIN  = 6;
  localparam int TO_SHORT = 4;
  localparam int N_TXN    = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic          i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
  state_e        dbg_state;

  // ---------------- short-timeout DUT signals ----------------
  logic          t_i_req, t_d_req, t_d_we, t_mem_ack;
  logic [AW-1:0] t_i_addr, t_d_addr, t_mem_addr;
  logic [DW-1:0] t_d_wdata, t_mem_rdata, t_i_rdata, t_d_rdata, t_mem_wdata;
  logic          t_i_gnt, t_i_rvalid, t_i_err, t_d_gnt, t_d_rvalid, t_d_err;
  logic          t_mem_req, t_mem_we;
  state_e        t_dbg_state;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_MAIN)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_SHORT)) u_dut_to (
    .clk(clk), .reset(reset),
    .i_req(t_i_req), .i_addr(t_i_addr), .i_gnt(t_i_gnt), .i_rvalid(t_i_rvalid),
    .i_rdata(t_i_rdata), .i_err(t_i_err),
    .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_gnt(t_d_gnt), .d_rvalid(t_d_rvalid), .d_rdata(t_d_rdata), .d_err(t_d_err),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata), .dbg_state_o(t_dbg_state)
  );

  // ---------------- vector types ----------------
  typedef struct packed {
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          i_gnt;
    logic          i_rvalid;
    logic          i_err;
    logic [DW-1:0] i_rdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic          d_err;
    logic [DW-1:0] d_rdata;
  } outs_t;

  typedef struct packed {
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
  } ins_t;

  typedef struct {
    string name;
    ins_t  in;
    outs_t exp;
  } vec_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [DW:0] exp_i_q[$];
  logic [DW:0] exp_d_q[$];
  int          cyc_i_q[$];
  int          cyc_d_q[$];
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic ins_t mk_in(input logic ir, input logic [AW-1:0] ia, input logic dr,
                                 input logic dwe, input logic [AW-1:0] da,
                                 input logic [DW-1:0] dwd, input logic ack,
                                 input logic [DW-1:0] rd);
    return {ir, ia, dr, dwe, da, dwd, ack, rd};
  endfunction

  function automatic outs_t mk_out(input logic mrq, input logic mwe, input logic [AW-1:0] ma,
                                   input logic [DW-1:0] mwd, input logic ig, input logic iv,
                                   input logic ie, input logic [DW-1:0] ird, input logic dg,
                                   input logic dv, input logic de, input logic [DW-1:0] drd);
    return {mrq, mwe, ma, mwd, ig, iv, ie, ird, dg, dv, de, drd};
  endfunction

  function automatic outs_t dut_outs();
    return {mem_req, mem_we, mem_addr, mem_wdata, i_gnt, i_rvalid, i_err, i_rdata,
            d_gnt, d_rvalid, d_err, d_rdata};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input ins_t v);
    i_req = v.i_req;  i_addr = v.i_addr;
    d_req = v.d_req;  d_we = v.d_we;  d_addr = v.d_addr;  d_wdata = v.d_wdata;
    mem_ack = v.mem_ack;  mem_rdata = v.mem_rdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    t_i_req = 1'b0; t_i_addr = '0; t_d_req = 1'b0; t_d_we = 1'b0;
    t_d_addr = '0; t_d_wdata = '0; t_mem_ack = 1'b0; t_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", dut_outs(), '0);
    chk("reset_state", dbg_state, IDLE);
    reset = 1'b0;
  endtask

  function automatic void add_vec(input string nm, input ins_t in, input outs_t exp);
    vec_t v;
    v.name = nm; v.in = in; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---------------- random-phase state ----------------
  req_t   i_cur, d_cur, fl_req;
  logic   i_pend, d_pend;
  owner_e last_served, got_side, want_side, rsp_side;
  int     fl_delay, fl_busy, done;
  logic [DW-1:0] fl_rdata;
  logic [DW:0]   exp_rsp;
  int            exp_cyc;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    // ---------- directed table: stray ack, fetch, write with late ack ----------
    add_vec("stray_ack_idle", mk_in(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF),
            mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec("idle_after_stray", mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec("fetch_busy_gnt", mk_in(0, 0, 0, 0, 0, 0, 1, 32'h0000_0013),
            mk_out(1, 0, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add_vec("fetch_resp", mk_in(0, 0, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 32'h100, 0, 0, 1, 0, 32'h13, 0, 0, 0, 0));
    add_vec("fetch_idle_hold", mk_in(0, 0, 1, 1, 32'h2000, 32'hDEAD_BEEF, 0, 0),
            mk_out(0, 0, 32'h100, 0, 0, 0, 0, 32'h13, 0, 0, 0, 0));
    add_vec("wr_busy0_gnt", mk_in(0, 0, 0, 0, 0, 0, 0, 0),
            mk_out(1, 1, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 32'h13, 1, 0, 0, 0));
    for (int k = 1; k < 5; k++)
      add_vec($sformatf("wr_busy%0d", k), mk_in(0, 0, 0, 0, 0, 0, 0, 0),
              mk_out(1, 1, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 32'h13, 0, 0, 0, 0));
    add_vec("wr_busy5_ack_at_limit", mk_in(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555),
            mk_out(1, 1, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 32'h13, 0, 0, 0, 0));
    add_vec("wr_resp", mk_in(0, 0, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 32'h13, 0, 1, 0, 0));
    add_vec("wr_idle_hold", mk_in(0, 0, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 32'h2000, 32'hDEAD_BEEF, 0, 0, 0, 32'h13, 0, 0, 0, 0));

    do_reset();
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      chk(vecs[k].name, dut_outs(), vecs[k].exp);
      drive(vecs[k].in);
    end

    // ---------- contention: both sides held from reset ----------
    begin
      owner_e order[$];
      owner_e exp_order[4];
      exp_order[0] = FETCH; exp_order[1] = DATA; exp_order[2] = FETCH; exp_order[3] = DATA;
      do_reset();
      drive(mk_in(1, 32'h300, 1, 0, 32'h400, 0, 1, 32'h77));
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
        @(negedge clk);
        if (i_gnt) order.push_back(FETCH);
        if (d_gnt) order.push_back(DATA);
      end
      drive('0);
      chk("contention_grant_count", order.size(), 4);
      for (int k = 0; k < 4 && k < order.size(); k++)
        chk($sformatf("contention_grant%0d", k), order[k], exp_order[k]);
    end

    // ---------- timeout on the short-limit instance ----------
    begin
      int   hi_cycles;
      logic seen;
      logic got_err;
      logic [DW-1:0] got_rd;
      do_reset();
      hi_cycles = 0; seen = 1'b0; got_err = 1'b0; got_rd = '1;
      t_d_req = 1'b1; t_d_we = 1'b0; t_d_addr = 32'h500; t_mem_rdata = 32'hABCD;
      for (int c = 0; c < 30 && !seen; c++) begin
        @(negedge clk);
        if (t_mem_req) hi_cycles++;
        if (t_d_gnt) t_d_req = 1'b0;
        if (t_d_rvalid) begin
          seen = 1'b1; got_err = t_d_err; got_rd = t_d_rdata;
        end
      end
      chk("timeout_rvalid_seen", seen, 1'b1);
      chk("timeout_mem_req_cycles", hi_cycles, TO_SHORT);
      chk("timeout_err", got_err, 1'b1);
      chk("timeout_rdata", got_rd, 0);
    end

    // ---------- reset in the middle of a fetch ----------
    begin
      logic saw_rvalid;
      do_reset();
      @(negedge clk);
      drive(mk_in(1, 32'h600, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive('0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midbusy_mem_req_drop", mem_req, 1'b0);
      chk("midbusy_state", dbg_state, IDLE);
      saw_rvalid = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (i_rvalid) saw_rvalid = 1'b1;
      end
      chk("midbusy_no_rvalid", saw_rvalid, 1'b0);
      drive(mk_in(1, 32'h700, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      #1;
      chk("after_release_state", dbg_state, IDLE);
      @(negedge clk);
      chk("after_release_gnt", {i_gnt, mem_req, mem_addr}, {1'b1, 1'b1, 32'h700});
      drive(mk_in(0, 0, 0, 0, 0, 0, 1, 32'h99));
      @(negedge clk);
      chk("after_release_resp", {i_rvalid, i_err, i_rdata}, {1'b1, 1'b0, 32'h99});
      drive('0);
    end

    // ---------- randomized traffic against a transaction-level model ----------
    do_reset();
    i_pend = 1'b0; d_pend = 1'b0; i_cur = '0; d_cur = '0;
    last_served = DATA; done = 0; fl_busy = 0; fl_delay = 0; fl_req = '0; fl_rdata = '0;
    for (int cyc = 0; cyc < 20000 && done < N_TXN; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (i_gnt || d_gnt) begin
        got_side = i_gnt ? FETCH : DATA;
        if (i_req && d_req) want_side = (last_served == DATA) ? FETCH : DATA;
        else                want_side = i_req ? FETCH : DATA;
        chk("rand_rr_winner", got_side, want_side);
        fl_req   = (got_side == FETCH) ? i_cur : d_cur;
        fl_busy  = 0;
        fl_delay = $urandom_range(0, 7);
        fl_rdata = $urandom;
        if (fl_delay < TO_MAIN) begin
          exp_rsp = {1'b0, fl_req.we ? '0 : fl_rdata};
          exp_cyc = fl_delay + 1;
        end else begin
          exp_rsp = {1'b1, {DW{1'b0}}};
          exp_cyc = TO_MAIN;
        end
        if (got_side == FETCH) begin
          exp_i_q.push_back(exp_rsp); cyc_i_q.push_back(exp_cyc); i_pend = 1'b0;
        end else begin
          exp_d_q.push_back(exp_rsp); cyc_d_q.push_back(exp_cyc); d_pend = 1'b0;
        end
      end
      if (mem_req) begin
        chk("rand_mem_fields", {mem_we, mem_addr, mem_wdata}, fl_req);
        if (fl_busy == fl_delay) begin
          mem_ack = 1'b1; mem_rdata = fl_rdata;
        end
        fl_busy++;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1; mem_rdata = $urandom;
      end
      if (i_rvalid || d_rvalid) begin
        rsp_side = i_rvalid ? FETCH : DATA;
        if (rsp_side == FETCH && exp_i_q.size() > 0) begin
          chk("rand_fetch_resp", {i_err, i_rdata}, exp_i_q.pop_front());
          chk("rand_fetch_busy_len", fl_busy, cyc_i_q.pop_front());
        end else if (rsp_side == DATA && exp_d_q.size() > 0) begin
          chk("rand_data_resp", {d_err, d_rdata}, exp_d_q.pop_front());
          chk("rand_data_busy_len", fl_busy, cyc_d_q.pop_front());
        end else begin
          chk("rand_unexpected_rvalid", 1'b1, 1'b0);
        end
        chk("rand_single_rvalid", i_rvalid && d_rvalid, 1'b0);
        last_served = rsp_side;
        done++;
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        i_cur  = '{we: 1'b0, addr: $urandom, wdata: '0};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        d_cur  = '{we: 1'($urandom_range(0, 1)), addr: $urandom, wdata: $urandom};
      end
      i_req = i_pend; i_addr = i_cur.addr;
      d_req = d_pend; d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata;
    end
    chk("rand_txn_count", done, N_TXN);
    chk("rand_queues_drained", exp_i_q.size() + exp_d_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
